// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction fetch stage with two ping-pong banks of BLK_DEPTH instructions.
// One bank drains to decode over a valid/ready handshake while the next
// sequential block is prefetched into the other bank. Also handles
// halt/resume and PC redirect (jump).
//
// Optional build macro:
//   IFETCH_PERF_EN  adds saturating performance counters
//                   (perfIssued, perfStall, perfJmp).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   blkReq / blkAddr    block request to memory; blkAddr is block-aligned
//   blkVld / blkData    block response; taken only while blkReq=1
//   instrVld / instrRdy issue handshake towards decode
//   instr / instrPc     issued instruction (NOP while instrVld=0) and its PC
//   incPc               resume pulse, used only while halted
//   jmpVld / jmpAddr    redirect pulse and target PC
//   halted              high while halted
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int INSTR_W   = 32,
    parameter int BLK_DEPTH = 16,
    parameter int PC_W      = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         blkReq,
    output logic [PC_W-1:0]              blkAddr,
    input  logic                         blkVld,
    input  logic [INSTR_W*BLK_DEPTH-1:0] blkData,
    output logic                         instrVld,
    input  logic                         instrRdy,
    output logic [INSTR_W-1:0]           instr,
    output logic [PC_W-1:0]              instrPc,
    input  logic                         incPc,
    input  logic                         jmpVld,
    input  logic [PC_W-1:0]              jmpAddr,
    output logic                         halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]                  perfIssued,
    output logic [31:0]                  perfStall,
    output logic [15:0]                  perfJmp
`endif
);

    localparam int                 OFF_W = $clog2(BLK_DEPTH);
    localparam logic [INSTR_W-1:0] NOP   = INSTR_W'(32'h6000_0000);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_t;

    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic               r_cur, w_cur_nxt;           // bank being issued from
    logic [1:0]         r_full, w_full_nxt;         // per-bank valid
    logic               r_req, w_req_nxt;
    logic [PC_W-1:0]    r_blk_addr, w_blk_addr_nxt;
    logic               r_discard, w_discard_nxt;   // drop next response (stale after jump)
    logic               w_wr_en;
    logic [INSTR_W-1:0] r_bank [2][BLK_DEPTH];

    logic [OFF_W-1:0]   w_off;
    logic [PC_W-1:0]    w_base;
    logic [INSTR_W-1:0] w_cur_instr;
    logic               w_last, w_xfer, w_accept, w_is_halt, w_fill_bank, w_adv;

    assign w_off       = r_pc[OFF_W-1:0];
    assign w_last      = &w_off;
    assign w_base      = {r_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_cur_instr = r_bank[r_cur][w_off];
    assign w_is_halt   = (w_cur_instr[30:29] == 2'b11);
    assign w_xfer      = (r_state == S_RUN) && instrRdy;
    assign w_accept    = r_req && blkVld;
    assign w_adv       = (w_xfer && !w_is_halt) || ((r_state == S_HALT) && incPc);
    // In FILL the outstanding request is for the current (empty) bank;
    // otherwise it is a prefetch into the other bank.
    assign w_fill_bank = (r_state == S_FILL) ? r_cur : ~r_cur;

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cur_nxt      = r_cur;
        w_full_nxt     = r_full;
        w_req_nxt      = r_req;
        w_blk_addr_nxt = r_blk_addr;
        w_discard_nxt  = r_discard;
        w_wr_en        = 1'b0;

        if (jmpVld) begin
            w_full_nxt     = 2'b00;
            w_pc_nxt       = jmpAddr;
            w_state_nxt    = S_FILL;
            w_req_nxt      = 1'b1;
            w_blk_addr_nxt = {jmpAddr[PC_W-1:OFF_W], {OFF_W{1'b0}}};
            // A request still in flight will return the old block; drop it.
            w_discard_nxt  = r_req && !blkVld;
        end else begin
            if (w_accept) begin
                if (r_discard) begin
                    w_discard_nxt = 1'b0;   // request stays up for the new address
                end else begin
                    w_wr_en                 = 1'b1;
                    w_full_nxt[w_fill_bank] = 1'b1;
                    w_req_nxt               = 1'b0;
                    if (r_state == S_FILL) w_state_nxt = S_RUN;
                end
            end

            if ((r_state == S_FILL) && !r_req) begin
                w_req_nxt      = 1'b1;
                w_blk_addr_nxt = w_base;
            end else if ((r_state != S_FILL) && !r_full[~r_cur] && !r_req) begin
                w_req_nxt      = 1'b1;
                w_blk_addr_nxt = w_base + PC_W'(BLK_DEPTH);
            end

            if (w_xfer && w_is_halt) begin
                // pc stays on the halt instruction; a drained bank is freed now.
                w_state_nxt = S_HALT;
                if (w_last) w_full_nxt[r_cur] = 1'b0;
            end else if (w_adv) begin
                w_pc_nxt    = r_pc + PC_W'(1);
                w_state_nxt = S_RUN;
                if (w_last) begin
                    // Always swap; the other bank is either full (no bubble,
                    // including a same-edge fill) or is the target of the
                    // request that FILL waits on.
                    w_full_nxt[r_cur] = 1'b0;
                    w_cur_nxt         = ~r_cur;
                    if (!w_full_nxt[~r_cur]) w_state_nxt = S_FILL;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_pc       <= '0;
            r_cur      <= 1'b0;
            r_full     <= 2'b00;
            r_req      <= 1'b1;
            r_blk_addr <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cur      <= w_cur_nxt;
            r_full     <= w_full_nxt;
            r_req      <= w_req_nxt;
            r_blk_addr <= w_blk_addr_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    // NOTE: bank storage is not reset; r_full gates its use, and skipping the reset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < BLK_DEPTH; i++) begin
                r_bank[w_fill_bank][i] <= blkData[i*INSTR_W +: INSTR_W];
            end
        end
    end

    assign blkReq   = r_req;
    assign blkAddr  = r_blk_addr;
    assign instrVld = (r_state == S_RUN);
    assign instr    = instrVld ? w_cur_instr : NOP;
    assign instrPc  = r_pc;
    assign halted   = (r_state == S_HALT);

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_issued, r_perf_stall;
    logic [15:0] r_perf_jmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
            r_perf_jmp    <= '0;
        end else begin
            // A jump overrides a transfer offered in the same cycle.
            if (w_xfer && !jmpVld && (r_perf_issued != '1))
                r_perf_issued <= r_perf_issued + 32'd1;
            if (((r_state == S_FILL) || (r_state == S_RUN)) && !instrVld && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (jmpVld && (r_perf_jmp != '1))
                r_perf_jmp <= r_perf_jmp + 16'd1;
        end
    end

    assign perfIssued = r_perf_issued;
    assign perfStall  = r_perf_stall;
    assign perfJmp    = r_perf_jmp;
`endif

endmodule
